// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path:
// parity-mode constants and the transmit FSM state type.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_cfg_if.sv
// Host-side write port and serial status of the FIFO-backed UART transmitter.
// master = host logic, slave = transmitter.
interface uart_tx_fifo_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Overflow;
  logic [CW-1:0]        o_Fifo_Count;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Overflow,
    input  o_Fifo_Count,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Overflow,
    output o_Fifo_Count,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Done
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO, power-of-2 depth, registered occupancy count.
// Ports: clk, rst_n, push/din, pop/dout, full, empty, count.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with write FIFO and configurable data/parity/stop format.
// Ports: i_Clock, i_Rst_n, tx (write handshake, count, serial line, status).
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input logic               i_Clock,
  input logic               i_Rst_n,
  uart_tx_fifo_cfg_if.slave tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  tx_state_e state;

  logic [BW-1:0]        baud;
  logic [IW-1:0]        idx;
  logic                 stop_cnt;
  logic [EW-1:0]        word;
  logic [DATA_BITS-1:0] data;

  logic          par_in;
  logic [EW-1:0] fifo_din;
  logic [EW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;

  logic bit_end;
  logic stop_last;
  logic frame_end;
  logic line_bit;

  logic serial_q;
  logic active_q;
  logic end_q;
  logic done_q;

  // Parity is folded into the stored entry so the line mux
  // never needs to recompute it from the shifting word.
  assign par_in   = (PARITY == PAR_ODD) ? ~^tx.i_Tx_Byte
                                        : ^tx.i_Tx_Byte;
  assign fifo_din = {par_in, tx.i_Tx_Byte};
  assign push     = tx.i_Tx_DV && !fifo_full;

  assign bit_end   = (baud == BAUD_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_cnt;
  assign frame_end = (state == ST_STOP) && bit_end && stop_last;
  assign pop       = !fifo_empty
                     && ((state == ST_IDLE) || frame_end);

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state    <= ST_IDLE;
      baud     <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
      word     <= '0;
    end else if (pop) begin
      word     <= fifo_dout;
      state    <= ST_START;
      baud     <= '0;
      idx      <= '0;
      stop_cnt <= 1'b0;
    end else if (state == ST_IDLE) begin
      baud <= '0;
    end else if (!bit_end) begin
      baud <= baud + 1'b1;
    end else begin
      baud <= '0;
      unique case (state)
        ST_START: state <= ST_DATA;
        ST_DATA: begin
          if (idx == IDX_LAST)
            state <= (PARITY != PAR_NONE) ? ST_PARITY
                                          : ST_STOP;
          else
            idx <= idx + 1'b1;
        end
        ST_PARITY: state <= ST_STOP;
        ST_STOP: begin
          if (stop_last) state <= ST_IDLE;
          else           stop_cnt <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data = word[DATA_BITS-1:0];

  always_comb begin
    line_bit = 1'b1;
    unique case (state)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = data[idx];
      ST_PARITY: line_bit = word[DATA_BITS];
      default:   line_bit = 1'b1;
    endcase
  end

  // The line, Active and Done are all one cycle behind the FSM;
  // Done needs a second stage so it lands after the last stop cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      serial_q <= 1'b1;
      active_q <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      serial_q <= line_bit;
      active_q <= (state != ST_IDLE);
      end_q    <= frame_end;
      done_q   <= end_q;
    end
  end

  assign tx.o_Tx_Serial   = serial_q;
  assign tx.o_Tx_Active   = active_q;
  assign tx.o_Tx_Done     = done_q;
  assign tx.o_Tx_Ready    = !fifo_full;
  assign tx.o_Tx_Overflow = tx.i_Tx_DV && fifo_full;
  assign tx.o_Fifo_Count  = fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: three configurations driven in parallel
// and compared every cycle against a frame-timeline reference model.
module tb_uart_tx_fifo_cfg;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic [8:0] wbyte;

  always #5 clk = ~clk;

  int cpb [NI] = '{4, 4, 3};
  int db  [NI] = '{8, 7, 8};
  int par [NI] = '{0, 2, 1};
  int sb  [NI] = '{1, 2, 1};
  int dep [NI] = '{4, 4, 2};

  logic [NI-1:0]      o_ser;
  logic [NI-1:0]      o_act;
  logic [NI-1:0]      o_done;
  logic [NI-1:0]      o_rdy;
  logic [NI-1:0]      o_ovf;
  logic [NI-1:0][3:0] o_cnt;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int P_CPB = (g == 2) ? 3 : 4;
    localparam int P_DB  = (g == 1) ? 7 : 8;
    localparam int P_PAR = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int P_SB  = (g == 1) ? 2 : 1;
    localparam int P_DEP = (g == 2) ? 2 : 4;

    uart_tx_fifo_cfg_if #(
      .DATA_BITS  (P_DB),
      .FIFO_DEPTH (P_DEP)
    ) bus ();

    assign bus.i_Tx_DV   = dv;
    assign bus.i_Tx_Byte = wbyte[P_DB-1:0];

    uart_tx_fifo_cfg #(
      .CLKS_PER_BIT (P_CPB),
      .DATA_BITS    (P_DB),
      .PARITY       (P_PAR),
      .STOP_BITS    (P_SB),
      .FIFO_DEPTH   (P_DEP)
    ) dut (
      .i_Clock (clk),
      .i_Rst_n (rst_n),
      .tx      (bus.slave)
    );

    assign o_ser[g]  = bus.o_Tx_Serial;
    assign o_act[g]  = bus.o_Tx_Active;
    assign o_done[g] = bus.o_Tx_Done;
    assign o_rdy[g]  = bus.o_Tx_Ready;
    assign o_ovf[g]  = bus.o_Tx_Overflow;
    assign o_cnt[g]  = 4'(bus.o_Fifo_Count);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued words, a popped word waiting to start,
  // and the frame currently on the line (bit vector + cycle position).
  logic [8:0]  qd   [NI][4];
  int          qh   [NI];
  int          qn   [NI];
  bit          pend [NI];
  logic [8:0]  pw   [NI];
  logic [15:0] fr   [NI];
  int          pos  [NI];
  int          rem  [NI];
  bit          edone[NI];

  function automatic int flen(int i);
    return (1 + db[i] + ((par[i] != 0) ? 1 : 0) + sb[i]) * cpb[i];
  endfunction

  function automatic logic [15:0] mkframe(int i, logic [8:0] w);
    logic [15:0] f;
    int ones;
    int k;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    k    = 1;
    for (int b = 0; b < db[i]; b++) begin
      f[k] = w[b];
      ones += int'(w[b]);
      k++;
    end
    if (par[i] == 1) f[k] = (ones % 2 == 0);
    if (par[i] == 2) f[k] = (ones % 2 == 1);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      qh[i]    = 0;
      qn[i]    = 0;
      pend[i]  = 1'b0;
      pw[i]    = '0;
      fr[i]    = '1;
      pos[i]   = 0;
      rem[i]   = 0;
      edone[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit acc;
    logic [8:0] m;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      acc      = dv && (qn[i] < dep[i]);
      edone[i] = (rem[i] == 1);
      if (pend[i]) begin
        fr[i]   = mkframe(i, pw[i]);
        pos[i]  = 0;
        rem[i]  = flen(i);
        pend[i] = 1'b0;
      end else if (rem[i] > 0) begin
        pos[i]++;
        rem[i]--;
      end
      // A word leaves the queue one cycle before its start bit.
      if (qn[i] > 0 && !pend[i] && rem[i] <= 1) begin
        pw[i]   = qd[i][qh[i]];
        qh[i]   = (qh[i] + 1) % dep[i];
        qn[i]--;
        pend[i] = 1'b1;
      end
      if (acc) begin
        m = 9'((1 << db[i]) - 1);
        qd[i][(qh[i] + qn[i]) % dep[i]] = wbyte & m;
        qn[i]++;
      end
    end
  endtask

  task automatic compare_all(string ph);
    logic es;
    for (int i = 0; i < NI; i++) begin
      es = (rem[i] > 0) ? fr[i][pos[i] / cpb[i]] : 1'b1;
      check($sformatf("%s c%0d serial", ph, i), o_ser[i], es);
      check($sformatf("%s c%0d active", ph, i), o_act[i], rem[i] > 0);
      check($sformatf("%s c%0d done", ph, i), o_done[i], edone[i]);
      check($sformatf("%s c%0d count", ph, i), o_cnt[i], qn[i]);
      check($sformatf("%s c%0d ready", ph, i), o_rdy[i], qn[i] < dep[i]);
    end
  endtask

  string phase = "reset";

  task automatic drive(logic d, logic [8:0] b);
    dv    = d;
    wbyte = b;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("%s c%0d overflow", phase, i), o_ovf[i],
            d && (qn[i] == dep[i]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(phase);
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++)
      if (rem[i] != 0 || qn[i] != 0 || pend[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(int limit);
    int n;
    n = 0;
    while (!all_idle() && n < limit) begin
      drive(1'b0, 9'h0);
      step();
      n++;
    end
    check({phase, " drained"}, all_idle(), 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 9'h0);
      step();
    end
  endtask

  int burst;

  initial begin
    rst_n = 1'b0;
    dv    = 1'b0;
    wbyte = '0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 9'h0);
      step();
    end
    rst_n = 1'b1;

    phase = "single";
    drive(1'b1, 9'h0A5); step();
    drain(200);
    drive(1'b1, 9'h055); step();
    drain(200);
    drive(1'b1, 9'h000); step();
    drain(200);
    drive(1'b1, 9'h001); step();
    drain(200);

    phase = "burst";
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 9'($urandom));
      step();
    end
    drain(2000);

    phase = "random";
    burst = 0;
    for (int k = 0; k < 4000; k++) begin
      if (burst == 0 && $urandom_range(0, 149) == 0)
        burst = $urandom_range(2, 8);
      if (burst > 0) begin
        drive(1'b1, 9'($urandom));
        burst--;
      end else begin
        drive($urandom_range(0, 29) == 0, 9'($urandom));
      end
      step();
    end
    drain(3000);

    phase = "midreset";
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 9'($urandom));
      step();
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 9'h0);
      step();
    end
    check("midreset c0 queued", qn[0], 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("async");
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 9'h0);
      step();
    end
    rst_n = 1'b1;
    phase = "postreset";
    for (int k = 0; k < 60; k++) begin
      drive(1'b0, 9'h0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_cfg.md
# uart_tx_fifo_cfg

Parametrised UART transmitter with a built-in transmit FIFO, configurable frame format, and a ready/valid write port. Host logic pushes words without waiting for each frame to finish. Frames go out back-to-back on the serial line with no idle gap while data is queued. It replaces the fixed 8N1 single-byte transmitter in UART paths that need parity, 2 stop bits, or burst transmission.

## Interface
- CLKS_PER_BIT, 434: clock cycles per serial bit; legal range ≥2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries; power of 2, ≥2.
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Tx_DV  in  1  write strobe; word accepted when i_Tx_DV && o_Tx_Ready.
- i_Tx_Byte  in  DATA_BITS  word to transmit.
- o_Tx_Ready  out  1  FIFO not full.
- o_Tx_Overflow  out  1  one-cycle pulse when a write is dropped.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  words queued, excluding the frame in flight.
- o_Tx_Active  out  1  high from first start-bit cycle to last stop-bit cycle.
- o_Tx_Serial  out  1  serial line; registered output.
- o_Tx_Done  out  1  one-cycle pulse per completed frame.

## Operation
- Reset values (asserted asynchronously):
  - o_Tx_Serial = 1, o_Tx_Ready = 1
  - o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Overflow = 0
  - o_Fifo_Count = 0; FIFO pointers and FSM cleared to IDLE.
- Reset mid-frame aborts the frame and empties the FIFO. The line returns high immediately. No Done pulse is issued.
- Frame order: start bit (0), data LSB first, parity (if PARITY≠0), STOP_BITS stop bits (1).
- Parity is computed over DATA_BITS bits and latched with the word. Odd parity sets the bit so the total number of ones is odd.
- FSM states and transitions:
  - IDLE → START when the FIFO is non-empty (pop).
  - START → DATA.
  - DATA → DATA until index = DATA_BITS-1, then → PARITY or STOP.
  - PARITY → STOP.
  - STOP → STOP until stop count = STOP_BITS-1, then → START if the FIFO is non-empty (pop), else IDLE.
- Each state holds for exactly CLKS_PER_BIT cycles.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- FIFO write when full is dropped (o_Tx_Overflow = 1 for that cycle). This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full, not empty): count unchanged.
- Push into an empty FIFO while IDLE: the word is popped on the next cycle.
- i_Tx_Byte is sampled only on an accepted write. Changes afterwards do not affect queued data.

## Timing
- Latency: write accepted at edge N with IDLE and FIFO empty → o_Tx_Serial low and o_Tx_Active high from edge N+2.
- Frame length is exactly CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle (zero idle).
- o_Tx_Done pulses on that same cycle, i.e. the first cycle after the last stop-bit cycle, in both the continue and go-IDLE cases.
- o_Tx_Active stays high across back-to-back frames.
- o_Tx_Ready and o_Fifo_Count are registered. They update the cycle after the push/pop edge.

## Structure
- Shared package uart_pkg:
  - parity-mode constants PAR_NONE / PAR_ODD / PAR_EVEN
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP)
- Sub-module uart_sync_fifo: WIDTH and DEPTH parameters, async active-low reset, push/pop/full/empty/count. It stores DATA_BITS+1 bits per entry (word plus precomputed parity).
- Top level holds the FSM, baud counter, bit index and stop counter.

## Test plan
- CLKS_PER_BIT=4, 8N1: write 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles wide; start bit at write+2; one Done pulse at cycle 40 after start.
- DATA_BITS=7, PARITY=2, STOP_BITS=2: write 0x55 → 7 data bits, parity 0, two stop bits; frame = 44 cycles.
- PARITY=1, write 0x00 → parity bit 1; write 0x01 → parity bit 0.
- FIFO_DEPTH=4: 6 writes on consecutive cycles while transmitting:
  - Ready drops after the queue holds 4.
  - The 6th write raises Overflow for one cycle.
  - The 5 accepted words go out with zero idle gap and Active continuously high.
- Assert i_Rst_n mid-data-bit with 3 words queued:
  - Serial = 1, Active = 0, Count = 0 immediately.
  - After release, the line stays idle with no Done pulse.
- Write and pop in the same cycle with the FIFO partially full → count unchanged; data order preserved.
